half_pwm_burst_sched: RTL

HALF_PWM_BURST_SCHED -- requirements
Module: half_pwm_burst_sched

---
 rtl/half_pwm_burst_sched_if.sv | 35 +++
 rtl/half_pwm_burst_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/half_pwm_burst_sched_if.sv
// half_pwm_burst_sched_if: configuration, burst control and pulse-block signals of the burst scheduler.
interface half_pwm_burst_sched_if #(
    parameter int _RAM_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic                  cfg_wr;
    logic [_RAM_WIDTH-1:0] cfg_die_period;
    logic [_RAM_WIDTH-1:0] cfg_pulse_period;
    logic [CNT_WIDTH-1:0]  cfg_burst_cnt;
    logic [CNT_WIDTH-1:0]  cfg_gap;
    logic [CNT_WIDTH-1:0]  cfg_timeout;
    logic                  start;
    logic                  abort;
    logic                  pulse_valid;
    logic [_RAM_WIDTH-1:0] die_period;
    logic [_RAM_WIDTH-1:0] pulse_period;
    logic                  pwm_en;
    logic                  pwm_dis;
    logic                  busy;
    logic                  done;
    logic                  fault;
    logic [CNT_WIDTH-1:0]  cycle_cnt;

    modport slave (
        input  cfg_wr, cfg_die_period, cfg_pulse_period, cfg_burst_cnt, cfg_gap, cfg_timeout,
        input  start, abort, pulse_valid,
        output die_period, pulse_period, pwm_en, pwm_dis, busy, done, fault, cycle_cnt
    );

    modport master (
        output cfg_wr, cfg_die_period, cfg_pulse_period, cfg_burst_cnt, cfg_gap, cfg_timeout,
        output start, abort, pulse_valid,
        input  die_period, pulse_period, pwm_en, pwm_dis, busy, done, fault, cycle_cnt
    );
endinterface

// File: rtl/half_pwm_burst_sched.sv
// half_pwm_burst_sched: schedules bursts of half-bridge A/B cycles with gap, watchdog and abort handling.
module half_pwm_burst_sched #(
    parameter int _RAM_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input logic                   io_clk,
    input logic                   io_rst,
    half_pwm_burst_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, GAP, ABORT} state_t;

    state_t                r_state;
    logic [_RAM_WIDTH-1:0] r_sh_die;
    logic [_RAM_WIDTH-1:0] r_sh_pulse;
    logic [_RAM_WIDTH-1:0] r_die;
    logic [_RAM_WIDTH-1:0] r_pulse;
    logic [CNT_WIDTH-1:0]  r_sh_burst;
    logic [CNT_WIDTH-1:0]  r_sh_gap;
    logic [CNT_WIDTH-1:0]  r_sh_to;
    logic [CNT_WIDTH-1:0]  r_cyc;
    logic [CNT_WIDTH-1:0]  r_gap;
    logic [CNT_WIDTH-1:0]  r_to;
    logic                  r_pwm_en;
    logic                  r_pwm_dis;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fault;
    logic                  r_ab;
    logic [CNT_WIDTH-1:0]  w_cyc_nxt;
    logic [CNT_WIDTH-1:0]  w_to_nxt;

    assign w_cyc_nxt = r_cyc + CNT_WIDTH'(1);
    assign w_to_nxt  = r_to + CNT_WIDTH'(1);

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            r_state    <= IDLE;
            r_sh_die   <= '0;
            r_sh_pulse <= '0;
            r_die      <= '0;
            r_pulse    <= '0;
            r_sh_burst <= '0;
            r_sh_gap   <= '0;
            r_sh_to    <= '0;
            r_cyc      <= '0;
            r_gap      <= '0;
            r_to       <= '0;
            r_pwm_en   <= 1'b0;
            r_pwm_dis  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_ab       <= 1'b0;
        end else begin
            r_pwm_en  <= 1'b0;
            r_done    <= 1'b0;
            r_pwm_dis <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cfg_wr) begin
                        r_sh_die   <= bus.cfg_die_period;
                        r_sh_pulse <= bus.cfg_pulse_period;
                        r_sh_burst <= bus.cfg_burst_cnt;
                        r_sh_gap   <= bus.cfg_gap;
                        r_sh_to    <= bus.cfg_timeout;
                    end
                    if (bus.start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_fault <= 1'b0;
                        r_cyc   <= '0;
                        r_die   <= bus.cfg_wr ? bus.cfg_die_period : r_sh_die;
                        r_pulse <= bus.cfg_wr ? bus.cfg_pulse_period : r_sh_pulse;
                    end
                end
                LOAD: begin
                    r_state  <= FIRE;
                    r_pwm_en <= 1'b1;
                end
                FIRE: begin
                    r_state <= WAIT;
                    r_to    <= '0;
                end
                WAIT: begin
                    if (bus.pulse_valid) begin
                        r_cyc <= w_cyc_nxt;
                        if (r_sh_burst != '0 && w_cyc_nxt == r_sh_burst) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_sh_gap == '0) begin
                            r_state  <= FIRE;
                            r_pwm_en <= 1'b1;
                        end else begin
                            r_state <= GAP;
                            r_gap   <= CNT_WIDTH'(1);
                        end
                    end else if (r_sh_to != '0) begin
                        r_to <= w_to_nxt;
                        if (w_to_nxt == r_sh_to) begin
                            r_state   <= ABORT;
                            r_fault   <= 1'b1;
                            r_pwm_dis <= 1'b1;
                            r_ab      <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == r_sh_gap) begin
                        r_state  <= FIRE;
                        r_pwm_en <= 1'b1;
                    end else begin
                        r_gap <= r_gap + CNT_WIDTH'(1);
                    end
                end
                ABORT: begin
                    r_ab      <= 1'b1;
                    r_pwm_dis <= ~r_ab;
                    if (r_ab) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // abort overrides whatever the state logic above decided, including a coincident pulse_valid
            if (bus.abort && r_state != IDLE && r_state != ABORT) begin
                r_state   <= ABORT;
                r_busy    <= 1'b1;
                r_pwm_dis <= 1'b1;
                r_pwm_en  <= 1'b0;
                r_done    <= 1'b0;
                r_ab      <= 1'b0;
                r_cyc     <= r_cyc;
                r_fault   <= r_fault;
            end
        end
    end

    assign bus.die_period   = r_die;
    assign bus.pulse_period = r_pulse;
    assign bus.pwm_en       = r_pwm_en;
    assign bus.pwm_dis      = r_pwm_dis;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.fault        = r_fault;
    assign bus.cycle_cnt    = r_cyc;
endmodule
